// File: rtl/uart_led_cmd.sv
// UART ASCII command decoder driving a mask/duty multi-channel PWM LED controller.
// Define UART_LED_CMD_ECHO_EN to write 'K' / '?' acknowledge bytes back to the UART.
module uart_led_cmd #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESCALE = 12
) (
    input  logic              hw_clk,
    input  logic              resetn,
    input  logic [31:0]       reg_dat_do,
    output logic              reg_dat_re,
    output logic              reg_dat_we,
    output logic [31:0]       reg_dat_di,
    input  logic              reg_dat_wait,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] mask,
    output logic [7:0]        duty
);
    localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [31:0] RX_EMPTY = 32'hFFFF_FFFF;
    localparam logic [7:0]  CH_K     = 8'h4B;
    localparam logic [7:0]  CH_Q     = 8'h3F;
    localparam logic [7:0]  CH_B     = 8'h42;
    localparam logic [7:0]  CH_CR    = 8'h0D;
    localparam logic [7:0]  CH_LF    = 8'h0A;

    typedef enum logic [2:0] {IDLE, POP, DECODE, ARG_HI, ARG_LO, RESP, RESP_WAIT} state_t;
    typedef enum logic [1:0] {ARG_NONE, ARG_PEND_HI, ARG_PEND_LO} arg_t;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46));
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] b);
        return 4'((b <= 8'h39) ? (b - 8'h30) : (b - 8'h37));
    endfunction

    state_t            state_q, state_d;
    arg_t              arg_q, arg_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic [3:0]        hi_q, hi_d;
    logic              re_d;
    logic [NUM_CH-1:0] mask_d;
    logic [7:0]        duty_d;
    logic              resp_req;
    logic [7:0]        resp_val;
    logic              rx_hex;
    logic [3:0]        rx_nib;
`ifdef UART_LED_CMD_ECHO_EN
    logic [7:0]        resp_q, resp_d, tx_q, tx_d;
    logic              we_d;
`else
    logic              unused_resp;
`endif

    assign rx_hex = is_hex(rx_byte_q);
    assign rx_nib = hex_val(rx_byte_q);

    // Byte-level command FSM; an argument byte re-enters through IDLE/POP like any other byte.
    always_comb begin
        state_d   = state_q;
        arg_d     = arg_q;
        rx_byte_d = rx_byte_q;
        hi_d      = hi_q;
        re_d      = 1'b0;
        mask_d    = mask;
        duty_d    = duty;
        resp_req  = 1'b0;
        resp_val  = CH_Q;
`ifdef UART_LED_CMD_ECHO_EN
        resp_d    = resp_q;
        tx_d      = tx_q;
        we_d      = reg_dat_we;
`endif
        case (state_q)
            IDLE: begin
                if (reg_dat_do != RX_EMPTY) begin
                    rx_byte_d = reg_dat_do[7:0];
                    re_d      = 1'b1;
                    state_d   = POP;
                end
            end
            POP: begin
                case (arg_q)
                    ARG_PEND_HI: state_d = ARG_HI;
                    ARG_PEND_LO: state_d = ARG_LO;
                    default:     state_d = DECODE;
                endcase
            end
            DECODE: begin
                state_d = IDLE;
                if (rx_hex) begin
                    mask_d   = rx_nib[NUM_CH-1:0];
                    resp_req = 1'b1;
                    resp_val = CH_K;
                end else if (rx_byte_q == CH_B) begin
                    arg_d = ARG_PEND_HI;
                end else if ((rx_byte_q != CH_CR) && (rx_byte_q != CH_LF)) begin
                    resp_req = 1'b1;
                end
            end
            ARG_HI: begin
                state_d = IDLE;
                arg_d   = ARG_NONE;
                if (rx_hex) begin
                    hi_d  = rx_nib;
                    arg_d = ARG_PEND_LO;
                end else begin
                    resp_req = 1'b1;
                end
            end
            ARG_LO: begin
                state_d  = IDLE;
                arg_d    = ARG_NONE;
                resp_req = 1'b1;
                if (rx_hex) begin
                    duty_d   = {hi_q, rx_nib};
                    resp_val = CH_K;
                end
            end
`ifdef UART_LED_CMD_ECHO_EN
            RESP: begin
                tx_d    = resp_q;
                we_d    = 1'b1;
                state_d = RESP_WAIT;
            end
            RESP_WAIT: begin
                if (!reg_dat_wait) begin
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef UART_LED_CMD_ECHO_EN
        if (resp_req) begin
            resp_d  = resp_val;
            state_d = RESP;
        end
`endif
    end

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            arg_q      <= ARG_NONE;
            rx_byte_q  <= '0;
            hi_q       <= '0;
            reg_dat_re <= 1'b0;
            mask       <= '0;
            duty       <= 8'hFF;
        end else begin
            state_q    <= state_d;
            arg_q      <= arg_d;
            rx_byte_q  <= rx_byte_d;
            hi_q       <= hi_d;
            reg_dat_re <= re_d;
            mask       <= mask_d;
            duty       <= duty_d;
        end
    end

`ifdef UART_LED_CMD_ECHO_EN
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            resp_q     <= '0;
            tx_q       <= '0;
            reg_dat_we <= 1'b0;
        end else begin
            resp_q     <= resp_d;
            tx_q       <= tx_d;
            reg_dat_we <= we_d;
        end
    end

    assign reg_dat_di = {24'h0, tx_q};
`else
    assign reg_dat_we  = 1'b0;
    assign reg_dat_di  = '0;
    assign unused_resp = ^{resp_req, resp_val, reg_dat_wait};
`endif

    // PWM timebase: prescaler steps a free-running counter; duty is applied without period sync.
    logic [PS_W-1:0]     ps_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] dq;

    assign dq = duty[7 -: PWM_BITS];

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            ps_cnt  <= '0;
            pwm_cnt <= '0;
            pwm_out <= '0;
        end else begin
            if (ps_cnt == PS_W'(PRESCALE - 1)) begin
                ps_cnt  <= '0;
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end else begin
                ps_cnt  <= ps_cnt + PS_W'(1);
            end
            pwm_out <= mask & {NUM_CH{pwm_cnt < dq}};
        end
    end
endmodule

// File: tb/tb_uart_led_cmd.sv
// Bench for uart_led_cmd: UART RX/TX model, byte-level command interpreter, PWM duty counting.
module tb_uart_led_cmd;
    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned PWM_BITS = 8;
    localparam int unsigned PRESCALE = 12;

    logic              hw_clk = 1'b0;
    logic              resetn;
    logic [31:0]       reg_dat_do = 32'hFFFF_FFFF;
    logic              reg_dat_re;
    logic              reg_dat_we;
    logic [31:0]       reg_dat_di;
    logic              reg_dat_wait;
    logic [NUM_CH-1:0] pwm_out;
    logic [NUM_CH-1:0] mask;
    logic [7:0]        duty;

    uart_led_cmd #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) dut (
        .hw_clk(hw_clk), .resetn(resetn), .reg_dat_do(reg_dat_do), .reg_dat_re(reg_dat_re),
        .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_wait(reg_dat_wait),
        .pwm_out(pwm_out), .mask(mask), .duty(duty)
    );

    always #5 hw_clk = ~hw_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_err = 0;
    int n_re    = 0;
    int n_we    = 0;
    logic prev_re = 1'b0;
    logic [7:0]  rx_q[$];
    logic [31:0] tx_log[$];
    logic [7:0]  exp_tx[$];
    int hi_cnt[NUM_CH];

    // Reference interpreter state
    logic [NUM_CH-1:0] mask_m;
    logic [7:0]        duty_m;
    logic [3:0]        hi_m;
    int                pend;

    // UART side: pop on the strobe, capture accepted writes, present the next RX byte.
    always @(negedge hw_clk) begin
        if (reg_dat_re) begin
            n_re++;
            if (prev_re) begin
                mon_err++;
                $error("FAIL re_back_to_back: observed 1 expected 0");
            end
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else begin
                mon_err++;
                $error("FAIL re_on_empty: observed 1 expected 0");
            end
        end
        prev_re = reg_dat_re;
        if (reg_dat_we) begin
            n_we++;
`ifndef UART_LED_CMD_ECHO_EN
            mon_err++;
            $error("FAIL we_without_echo: observed 1 expected 0");
`endif
            if (!reg_dat_wait) tx_log.push_back(reg_dat_di);
        end
        reg_dat_do = (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hw_clk);
        #1;
    endtask

    task automatic model_reset();
        mask_m = '0;
        duty_m = 8'hFF;
        hi_m   = '0;
        pend   = 0;
        exp_tx.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic       h;
        logic [3:0] v;
        h = ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46));
        v = (b <= 8'h39) ? 4'(b - 8'h30) : 4'(b - 8'h41 + 8'd10);
        if (pend == 1) begin
            pend = 0;
            if (h) begin
                hi_m = v;
                pend = 2;
            end else exp_tx.push_back(8'h3F);
        end else if (pend == 2) begin
            pend = 0;
            if (h) begin
                duty_m = {hi_m, v};
                exp_tx.push_back(8'h4B);
            end else exp_tx.push_back(8'h3F);
        end else if (h) begin
            mask_m = NUM_CH'(v);
            exp_tx.push_back(8'h4B);
        end else if (b == 8'h42) pend = 1;
        else if ((b != 8'h0D) && (b != 8'h0A)) exp_tx.push_back(8'h3F);
    endtask

    task automatic wait_rx_empty(input string tag);
        int n;
        n = 0;
        while ((rx_q.size() != 0) && (n < 100)) begin
            tick();
            n++;
        end
        check(tag, 32'(rx_q.size()), 32'd0);
    endtask

    task automatic settle();
        int n;
        wait_rx_empty("rx_popped");
        repeat (4) tick();
        n = 0;
        while (reg_dat_we && (n < 200)) begin
            tick();
            n++;
        end
        check("tx_accepted", 32'(reg_dat_we), 32'd0);
        tick();
    endtask

    task automatic check_tx();
        logic [31:0] got;
`ifdef UART_LED_CMD_ECHO_EN
        while (exp_tx.size() != 0) begin
            if (tx_log.size() != 0) got = tx_log.pop_front();
            else got = 32'hDEAD_BEEF;
            check("tx_byte", got, {24'h0, exp_tx.pop_front()});
        end
`else
        got = 32'h0;
        exp_tx.delete();
`endif
        check("tx_extra", 32'(tx_log.size()) | got, 32'd0);
    endtask

    task automatic check_state();
        check("mask", 32'(mask), 32'(mask_m));
        check("duty", 32'(duty), 32'(duty_m));
    endtask

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
        model_byte(b);
        settle();
        check_tx();
        check_state();
    endtask

    // Over one full PWM period every counter value occurs PRESCALE times.
    task automatic check_pwm(input string tag);
        int win, expv;
        win = int'(PRESCALE) << PWM_BITS;
        for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
        repeat (win) begin
            tick();
            for (int i = 0; i < NUM_CH; i++) hi_cnt[i] += int'(pwm_out[i]);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            expv = mask_m[i] ? (int'(duty_m) >> (8 - PWM_BITS)) * int'(PRESCALE) : 0;
            check($sformatf("%s_ch%0d", tag, i), 32'(hi_cnt[i]), 32'(expv));
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned k, v;
        k = $urandom_range(0, 9);
        v = $urandom_range(0, 15);
        case (k)
            0, 1, 2, 3: return (v < 10) ? 8'(8'h30 + v) : 8'(8'h37 + v);
            4, 5:       return 8'h42;
            6:          return (v[0]) ? 8'h0D : 8'h0A;
            7:          return 8'(8'h61 + $urandom_range(0, 5));
            8:          return 8'(8'h47 + $urandom_range(0, 19));
            default:    return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int n;
        int stall_err;
        resetn       = 1'b0;
        reg_dat_wait = 1'b0;
        model_reset();
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_mask", 32'(mask), 32'd0);
        check("rst_duty", 32'(duty), 32'hFF);
        check("rst_re", 32'(reg_dat_re), 32'd0);
        check("rst_we", 32'(reg_dat_we), 32'd0);
        check("rst_di", reg_dat_di, 32'd0);
        check_pwm("idle_pwm");
        check("idle_no_re", 32'(n_re), 32'd0);
        check("idle_no_we", 32'(n_we), 32'd0);

        // '5' with cycle-level latency checks from the pop strobe
        rx_q.push_back(8'h35);
        model_byte(8'h35);
        n = 0;
        while (!reg_dat_re && (n < 20)) begin
            tick();
            n++;
        end
        check("pop_seen", 32'(reg_dat_re), 32'd1);
        tick();
        check("pop_single", 32'(reg_dat_re), 32'd0);
        check("mask_before_decode", 32'(mask), 32'd0);
        tick();
        check("mask_at_decode", 32'(mask), 32'b101);
        check("we_not_yet", 32'(reg_dat_we), 32'd0);
        tick();
`ifdef UART_LED_CMD_ECHO_EN
        check("we_3_after_pop", 32'(reg_dat_we), 32'd1);
        check("di_k", reg_dat_di, 32'h4B);
`else
        check("we_tied_low", 32'(reg_dat_we), 32'd0);
`endif
        check("pwm_after_mask", 32'(pwm_out & 3'b010), 32'd0);
        settle();
        check_tx();
        check_state();
        check_pwm("pwm_mask5");

        send(8'h37);
        send(8'h42);
        send(8'h34);
        send(8'h30);
        check_pwm("pwm_duty40");

        send(8'h42);
        send(8'h47);
        send(8'h31);
        send(8'h42);
        send(8'h30);
        send(8'h38);
        send(8'h36);
        check_pwm("pwm_duty08");
        send(8'h42);
        send(8'h30);
        send(8'h30);
        send(8'h37);
        check_pwm("pwm_duty00");

        // Response held off by a busy UART; the next RX byte must stay queued
        reg_dat_wait = 1'b1;
        rx_q.push_back(8'h33);
        model_byte(8'h33);
        wait_rx_empty("hold_pop1");
        rx_q.push_back(8'h36);
        repeat (4) tick();
`ifdef UART_LED_CMD_ECHO_EN
        stall_err = 0;
        repeat (50) begin
            tick();
            if (!(reg_dat_we && (reg_dat_di == 32'h4B) && (rx_q.size() == 1))) stall_err++;
        end
        check("hold_stable", 32'(stall_err), 32'd0);
        check("hold_mask", 32'(mask), 32'(mask_m));
`else
        stall_err = 0;
        repeat (50) tick();
        check("hold_ignored", 32'(rx_q.size()) | 32'(stall_err), 32'd0);
`endif
        reg_dat_wait = 1'b0;
        model_byte(8'h36);
        settle();
        check_tx();
        check_state();

        // Reset mid-argument, with a pending TX when echo is built in
        send(8'h42);
        send(8'h37);
`ifdef UART_LED_CMD_ECHO_EN
        reg_dat_wait = 1'b1;
        rx_q.push_back(8'h39);
        wait_rx_empty("rst_pop9");
        repeat (4) tick();
        check("rst_tx_pending", 32'(reg_dat_we), 32'd1);
`endif
        resetn = 1'b0;
        #1;
        check("rst2_mask", 32'(mask), 32'd0);
        check("rst2_duty", 32'(duty), 32'hFF);
        check("rst2_we", 32'(reg_dat_we), 32'd0);
        check("rst2_re", 32'(reg_dat_re), 32'd0);
        check("rst2_pwm", 32'(pwm_out), 32'd0);
        tick();
        tick();
        resetn       = 1'b1;
        reg_dat_wait = 1'b0;
        model_reset();
        repeat (5) tick();
        check("rst2_tx_dropped", 32'(tx_log.size()), 32'd0);
        send(8'h41);
        check("rst2_mask_a", 32'(mask), 32'b010);

        // Randomized byte stream against the interpreter
        for (int i = 0; i < 40; i++) send(rand_byte());
        check_pwm("pwm_random");

        check("monitor_errors", 32'(mon_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
